// File: rtl/waveform_streamer.sv
// rtl/waveform_streamer.sv - frames waveform buffer samples into a byte stream for a UART.
// Optional trailing XOR checksum byte: define WAVE_STREAMER_CHECKSUM_EN.
module waveform_streamer #(
    parameter int NUM_SAMPLES = 1000,
    parameter int ADDR_W      = 10
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       wave_number,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [13:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

`ifdef WAVE_STREAMER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, HDR, FETCH, WAIT, SAMP_HI, SAMP_LO, CSUM, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, HDR, FETCH, WAIT, SAMP_HI, SAMP_LO, DONE
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       wave_q, wave_d;
    logic [13:0]       samp_q, samp_d;

    // The index register doubles as the read address so it holds while idle.
    assign rd_addr = idx_q;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            idx_q   <= '0;
            wave_q  <= '0;
            samp_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            wave_q  <= wave_d;
            samp_q  <= samp_d;
        end
    end

`ifdef WAVE_STREAMER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    // Covers every transferred byte after the 0x5A sync byte.
    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start) begin
            csum_d = '0;
        end else if (tx_valid && tx_ready &&
                     ((state_q == HDR && bcnt_q[1]) ||
                      state_q == SAMP_HI || state_q == SAMP_LO)) begin
            csum_d = csum_q ^ tx_data;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        idx_d    = idx_q;
        wave_d   = wave_q;
        samp_d   = samp_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    wave_d  = wave_number;
                    bcnt_d  = 2'd0;
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                case (bcnt_q)
                    2'd0:    tx_data = 8'hA5;
                    2'd1:    tx_data = 8'h5A;
                    2'd2:    tx_data = wave_q[15:8];
                    default: tx_data = wave_q[7:0];
                endcase
                if (tx_ready) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        idx_d   = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                samp_d  = rd_data;
                state_d = SAMP_HI;
            end
            SAMP_HI: begin
                tx_valid = 1'b1;
                tx_data  = {2'b00, samp_q[13:8]};
                if (tx_ready) begin
                    state_d = SAMP_LO;
                end
            end
            SAMP_LO: begin
                tx_valid = 1'b1;
                tx_data  = samp_q[7:0];
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
`ifdef WAVE_STREAMER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
`ifdef WAVE_STREAMER_CHECKSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/waveform_streamer.md
WAVEFORM_STREAMER -- requirements
Module: waveform_streamer

Interface
REQ-001 Parameter NUM_SAMPLES, default 1000: samples per frame.
REQ-002 Parameter ADDR_W, default 10: sample address width; 2^ADDR_W SHALL be at least NUM_SAMPLES.
REQ-003 sys_clk  in  1  single clock; all logic SHALL be rising-edge on sys_clk.
REQ-004 reset_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 start  in  1  one-cycle request to send one frame.
REQ-006 wave_number  in  16  trigger count; SHALL be sampled on an accepted start.
REQ-007 rd_addr  out  ADDR_W  sample read address to the waveform buffer.
REQ-008 rd_data  in  14  unsigned ADC sample; valid exactly 1 cycle after rd_addr.
REQ-009 tx_data  out  8  byte to UART transmitter.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  UART can accept a byte.
REQ-012 busy  out  1  high from accepted start until done.
REQ-013 done  out  1  one-cycle pulse after the last byte transfers.

Function
REQ-014 A byte SHALL transfer on a cycle where tx_valid and tx_ready are both high.
REQ-015 tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
REQ-016 tx_valid SHALL NOT drop before its transfer.
REQ-017 Frame order SHALL be: 0xA5, 0x5A, wave_number[15:8], wave_number[7:0], then per sample i=0..NUM_SAMPLES-1: {2'b00,s[13:8]}, s[7:0], then the optional checksum (REQ-030).
REQ-018 States SHALL be IDLE, HDR, FETCH, WAIT, SAMP_HI, SAMP_LO, CSUM, DONE.
REQ-019 IDLE -> HDR on start; start while busy SHALL be ignored.
REQ-020 HDR SHALL send 4 bytes via a 2-bit byte counter, then go to FETCH with sample index 0.
REQ-021 FETCH SHALL drive rd_addr=index and go to WAIT; WAIT SHALL capture rd_data into a 14-bit register and go to SAMP_HI.
REQ-022 SAMP_HI -> SAMP_LO on transfer.
REQ-023 SAMP_LO on transfer: if index==NUM_SAMPLES-1, go to CSUM (macro defined) or DONE; else increment index and go to FETCH.
REQ-024 DONE SHALL assert done for one cycle, deassert busy, and return to IDLE.
REQ-025 Sample capture SHALL use the latched register only; rd_data changes outside WAIT SHALL NOT alter the output.
REQ-026 Index SHALL NOT wrap past NUM_SAMPLES-1; rd_addr SHALL hold its last value while idle.
REQ-027 tx_ready held high SHALL give one transfer per cycle in HDR/SAMP states, plus 2 non-transfer cycles (FETCH, WAIT) per sample.

Reset
REQ-028 On reset_n low: state=IDLE, tx_valid=0, tx_data=0, rd_addr=0, busy=0, done=0, counters=0, checksum=0; this SHALL take effect immediately, including mid-frame.
REQ-029 After reset release, no byte SHALL be emitted until a new start.

Configuration
REQ-030 Macro WAVE_STREAMER_CHECKSUM_EN defined: CSUM SHALL send one byte equal to the XOR of all bytes after 0x5A, then go to DONE.
REQ-031 Macro absent: no checksum register or CSUM state; frame length SHALL be 4+2*NUM_SAMPLES bytes.

Verification
REQ-032 NUM_SAMPLES=4, rd_data=addr*0x101, wave_number=0x1234, tx_ready=1 -> bytes A5 5A 12 34 00 00 01 01 02 02 03 03, done pulse, busy low.
REQ-033 Same stimulus, tx_ready toggling 1-of-3 cycles -> identical byte sequence, tx_data stable during every stall.
REQ-034 Macro defined, REQ-032 stimulus -> checksum byte 0x26 appended; 13 bytes total.
REQ-035 Second start pulse mid-frame -> ignored, exactly one frame sent.
REQ-036 reset_n low during sample 2 -> tx_valid=0, busy=0 immediately; next start -> full frame from header.
REQ-037 Sample 0x3FFF at index NUM_SAMPLES-1 -> bytes 3F FF, then done; rd_addr never exceeds NUM_SAMPLES-1.
